frame_stream_tx: RTL and testbench

FRAME_STREAM_TX -- requirements
Module: frame_stream_tx

---
 rtl/frame_stream_pkg.sv | 31 +++
 rtl/stream_skid_fifo.sv | 63 ++++++
 rtl/frame_stream_tx.sv | 149 ++++++++++++++
 tb/tb_frame_stream_tx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_stream_pkg.sv
// Shared types and constants for the frame streaming transmitter:
// FSM encoding, output FIFO depth, per-pixel flags and the read-credit rule.
package frame_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int FIFO_DEPTH = 2;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } px_flags_t;

  localparam int FLAGS_W = $bits(px_flags_t);

  // A read may go out only if every pixel already in flight (stored or on the
  // memory bus) still has a FIFO slot once this cycle's pop has been taken.
  function automatic logic credit_ok(input logic [1:0] occ,
                                     input logic       pend,
                                     input logic       pop);
    logic [2:0] used;
    used = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
    return used < 3'(FIFO_DEPTH);
  endfunction

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry output FIFO holding pixel data plus frame flags; the head entry
// stays put while the consumer stalls, and push+pop together keep occupancy.
module stream_skid_fifo
  import frame_stream_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o
);

  localparam logic [1:0] DEPTH_C = 2'(FIFO_DEPTH);

  logic [W-1:0] mem_q [FIFO_DEPTH];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;
  logic         pop_fire;
  logic         push_fire;

  assign pop_fire  = pop_i && (count_q != 2'd0);
  assign push_fire = push_i && ((count_q < DEPTH_C) || pop_fire);

  always_comb begin
    count_d = count_q;
    case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_fire) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_fire) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/frame_stream_tx.sv
// Frame streaming transmitter: walks a frame buffer in raster order, reads it
// one pixel per cycle under FIFO credit control, and streams pixels with flags.
module frame_stream_tx
  import frame_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_CNT   = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [LINE_CNT-1:0]   h_size_i,
  input  logic [LINE_CNT-1:0]   v_size_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  sof_o,
  output logic                  eol_o,
  output logic                  eof_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            dbg_state_o
);

  // Handshake: a pixel moves on every rising edge where valid_o && ready_i;
  // valid_o never waits for ready_i, and data/flags hold while stalled.

  localparam int FW = DATA_WIDTH + FLAGS_W;

  state_e                state_q;
  logic [LINE_CNT-1:0]   h_q;
  logic [LINE_CNT-1:0]   v_q;
  logic [LINE_CNT-1:0]   x_q;
  logic [LINE_CNT-1:0]   y_q;
  logic [LINE_CNT-1:0]   x_d;
  logic [LINE_CNT-1:0]   y_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  pend_q;
  px_flags_t             pend_flags_q;
  logic                  done_q;

  logic                  last_rd;
  logic                  issue;
  logic                  pop;
  px_flags_t             rd_flags;
  px_flags_t             head_flags;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  fifo_valid;
  logic [FW-1:0]         fifo_head;
  logic [1:0]            fifo_count;

  always_comb begin
    last_rd      = (x_q == h_q) && (y_q == v_q);
    rd_flags.sof = (x_q == '0) && (y_q == '0);
    rd_flags.eol = (x_q == h_q);
    rd_flags.eof = last_rd;
    pop          = fifo_valid && ready_i;
    issue        = (state_q == ST_RUN) && credit_ok(fifo_count, pend_q, pop);
    addr_d       = addr_q + ADDR_WIDTH'(1);
    x_d          = x_q + LINE_CNT'(1);
    y_d          = y_q;
    if (x_q == h_q) begin
      x_d = '0;
      y_d = y_q + LINE_CNT'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      h_q          <= '0;
      v_q          <= '0;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      pend_q       <= 1'b0;
      pend_flags_q <= '0;
      done_q       <= 1'b0;
    end else begin
      // Flags travel one cycle behind the read so they meet its data.
      pend_q       <= issue;
      pend_flags_q <= rd_flags;
      done_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            h_q     <= h_size_i;
            v_q     <= v_size_i;
            addr_q  <= base_addr_i;
            x_q     <= '0;
            y_q     <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (issue) begin
            addr_q <= addr_d;
            x_q    <= x_d;
            y_q    <= y_d;
            if (last_rd) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && head_flags.eof) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  stream_skid_fifo #(
    .W (FW)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (pend_q),
    .push_data_i ({pend_flags_q, mem_rd_data_i}),
    .pop_i       (ready_i),
    .valid_o     (fifo_valid),
    .data_o      (fifo_head),
    .count_o     (fifo_count)
  );

  assign head_data     = fifo_head[DATA_WIDTH-1:0];
  assign head_flags    = fifo_head[FW-1:DATA_WIDTH];

  assign mem_rd_en_o   = issue;
  assign mem_rd_addr_o = addr_q;
  assign valid_o       = fifo_valid;
  assign data_o        = head_data;
  assign sof_o         = head_flags.sof;
  assign eol_o         = head_flags.eol;
  assign eof_o         = head_flags.eof;
  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = done_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_frame_stream_tx.sv
// Directed bench for frame_stream_tx: raster streaming, backpressure,
// single-pixel frames, ignored restarts, mid-frame reset and address wrap.
module tb_frame_stream_tx;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [11:0] h_size_i;
  logic [11:0] v_size_i;
  logic [31:0] base_addr_i;
  logic        mem_rd_en_o;
  logic [31:0] mem_rd_addr_o;
  logic [7:0]  mem_rd_data_i;
  logic        valid_o;
  logic        ready_i;
  logic [7:0]  data_o;
  logic        sof_o;
  logic        eol_o;
  logic        eof_o;
  logic        busy_o;
  logic        done_o;
  logic [1:0]  dbg_state_o;

  int n_cmp = 0;
  int n_err = 0;

  frame_stream_tx #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (32),
    .LINE_CNT   (12)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .h_size_i      (h_size_i),
    .v_size_i      (v_size_i),
    .base_addr_i   (base_addr_i),
    .mem_rd_en_o   (mem_rd_en_o),
    .mem_rd_addr_o (mem_rd_addr_o),
    .mem_rd_data_i (mem_rd_data_i),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .data_o        (data_o),
    .sof_o         (sof_o),
    .eol_o         (eol_o),
    .eof_o         (eof_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .dbg_state_o   (dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // frame memory: each word holds its own address LSBs, one-cycle latency
  always @(posedge clk) begin
    if (mem_rd_en_o) mem_rd_data_i <= mem_rd_addr_o[7:0];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, valid_o, 1'b0);
    chk({tag, "_rd_en"}, mem_rd_en_o, 1'b0);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_done"}, done_o, 1'b0);
    chk({tag, "_flags"}, {sof_o, eol_o, eof_o}, 3'b000);
    chk({tag, "_data"}, data_o, 8'h00);
    chk({tag, "_addr"}, mem_rd_addr_o, 32'h0);
  endtask

  // driver: start pulse; the frame begins on the following edge
  task automatic start_frame(input logic [11:0] h, input logic [11:0] v, input logic [31:0] base);
    @(negedge clk);
    start_i     = 1'b1;
    h_size_i    = h;
    v_size_i    = v;
    base_addr_i = base;
    ready_i     = 1'b1;
  endtask

  // Streams one frame of n_px pixels, w per line; pat 0 = always ready,
  // pat 1 = ready 1,0,0,1 repeating; poke re-pulses start with other sizes.
  task automatic stream(input int n_px, input int w, input int pat, input bit poke,
                        input logic [31:0] base);
    int         got = 0;
    int         cyc = 0;
    int         reads = 0;
    int         in_flight = 0;
    bit         stalled = 1'b0;
    logic [10:0] held = '0;
    logic       acc;
    logic [31:0] exp_a;
    while (got < n_px && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start_i = poke && (cyc == 4);
      if (poke && cyc == 4) begin
        h_size_i    = 12'd7;
        v_size_i    = 12'd5;
        base_addr_i = 32'h500;
      end
      ready_i = (pat == 0) ? 1'b1 : ((cyc % 4) == 1 || (cyc % 4) == 0);
      #1;
      acc = valid_o && ready_i;
      if (cyc == 1) begin
        chk("lat_rd_en", mem_rd_en_o, 1'b1);
        chk("state_run", dbg_state_o, 2'd1);
        chk("busy_run", busy_o, 1'b1);
      end
      if (stalled) begin
        chk("stall_valid", valid_o, 1'b1);
        chk("stall_hold", {sof_o, eol_o, eof_o, data_o}, held);
      end
      if (mem_rd_en_o) begin
        exp_a = base + 32'(reads);
        chk("rd_addr", mem_rd_addr_o, exp_a);
        chk("credit", (in_flight - int'(acc)) < 2, 1'b1);
        reads++;
      end
      if (acc) begin
        exp_a = base + 32'(got);
        chk("px_data", data_o, exp_a[7:0]);
        chk("px_sof", sof_o, got == 0);
        chk("px_eol", eol_o, (got % w) == (w - 1));
        chk("px_eof", eof_o, got == n_px - 1);
        if (pat == 0) chk("px_cycle", cyc, 3 + got);
        got++;
      end
      chk("no_early_done", done_o, 1'b0);
      stalled   = valid_o && !ready_i;
      held      = {sof_o, eol_o, eof_o, data_o};
      in_flight = in_flight + int'(mem_rd_en_o) - int'(acc);
    end
    chk("frame_pixels", got, n_px);
    chk("frame_reads", reads, n_px);
    @(negedge clk);
    start_i = 1'b0;
    #1;
    chk("done_pulse", done_o, 1'b1);
    chk("done_busy", busy_o, 1'b0);
    chk("done_valid", valid_o, 1'b0);
    chk("done_rd_en", mem_rd_en_o, 1'b0);
    @(negedge clk);
    #1;
    chk("done_clear", done_o, 1'b0);
  endtask

  initial begin
    int acc_cnt;
    rst_n         = 1'b0;
    start_i       = 1'b0;
    h_size_i      = '0;
    v_size_i      = '0;
    base_addr_i   = '0;
    ready_i       = 1'b0;
    mem_rd_data_i = '0;

    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 4x2 frame at 0x100, ready held high
    start_frame(12'd3, 12'd1, 32'h100);
    stream(8, 4, 0, 1'b0, 32'h100);

    // same frame under 1,0,0,1 backpressure
    start_frame(12'd3, 12'd1, 32'h100);
    stream(8, 4, 1, 1'b0, 32'h100);

    // single-pixel frame
    start_frame(12'd0, 12'd0, 32'h200);
    stream(1, 1, 0, 1'b0, 32'h200);

    // restart request mid-frame is ignored
    start_frame(12'd3, 12'd1, 32'h100);
    stream(8, 4, 0, 1'b1, 32'h100);

    // reset after three accepted pixels aborts the frame
    start_frame(12'd3, 12'd1, 32'h100);
    acc_cnt = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      #1;
      if (valid_o && ready_i) acc_cnt++;
    end
    chk("pre_reset_pixels", acc_cnt, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(negedge clk);
    #1;
    chk("reset_no_done", done_o, 1'b0);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk("post_reset_done", done_o, 1'b0);
      chk("post_reset_idle", dbg_state_o, 2'd0);
    end
    start_frame(12'd3, 12'd1, 32'h100);
    stream(8, 4, 0, 1'b0, 32'h100);

    // address wraps past the top of the address space
    start_frame(12'd3, 12'd0, 32'hFFFF_FFFE);
    stream(4, 4, 0, 1'b0, 32'hFFFF_FFFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
